// File: rtl/lieat_exu_pkg.sv
// Opcode encodings, FSM state type and small helpers shared by the shared execution unit.
package lieat_exu_pkg;

   localparam int OPW = 5;
   typedef logic [OPW-1:0] op_t;

   localparam op_t OP_ADD  = 5'd0;
   localparam op_t OP_SUB  = 5'd1;
   localparam op_t OP_XOR  = 5'd2;
   localparam op_t OP_OR   = 5'd3;
   localparam op_t OP_AND  = 5'd4;
   localparam op_t OP_SLL  = 5'd5;
   localparam op_t OP_SRL  = 5'd6;
   localparam op_t OP_SRA  = 5'd7;
   localparam op_t OP_SLT  = 5'd8;
   localparam op_t OP_SLTU = 5'd9;
   localparam op_t OP_LUI  = 5'd10;
   localparam op_t OP_BEQ  = 5'd11;
   localparam op_t OP_BNE  = 5'd12;
   localparam op_t OP_BLT  = 5'd13;
   localparam op_t OP_BGE  = 5'd14;
   localparam op_t OP_BLTU = 5'd15;
   localparam op_t OP_BGEU = 5'd16;

   typedef enum logic [1:0] {IDLE, SHIFT, OUT} exu_state_e;

   typedef struct packed {
      logic left;
      logic arith;
   } shctl_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/lieat_exu_share_rr_if.sv
// Requester/consumer bundle of the shared execution unit; master = requesters+consumer side.
interface lieat_exu_share_rr_if #(
   parameter int XLEN = 32,
   parameter int NREQ = 3,
   parameter int OPW  = 5
);
   localparam int SW = lieat_exu_pkg::clog2(NREQ);

   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*OPW-1:0]  req_op;
   logic [NREQ*XLEN-1:0] req_op1;
   logic [NREQ*XLEN-1:0] req_op2;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [XLEN-1:0]      rsp_result;
   logic                 rsp_cmp;
   logic [SW-1:0]        rsp_src;

   modport master (
      output req_valid, req_op, req_op1, req_op2, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_cmp, rsp_src
   );

   modport slave (
      input  req_valid, req_op, req_op1, req_op2, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_cmp, rsp_src
   );

endinterface

// File: rtl/lieat_rr_arb.sv
// Round-robin pick: first requester at or after ptr (with wrap); grant gated by en, index always valid.
module lieat_rr_arb #(
   parameter int NREQ = 3,
   parameter int SW   = lieat_exu_pkg::clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [SW-1:0]   ptr_i,
   input  logic            en_i,
   output logic [NREQ-1:0] grant_o,
   output logic [SW-1:0]   idx_o
);

   logic found;

   always_comb begin
      found   = 1'b0;
      idx_o   = '0;
      grant_o = '0;
      // k is the distance from ptr; channel i sits at distance k either directly or after wrapping
      for (int k = 0; k < NREQ; k++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!found && req_i[i] &&
                ((int'(ptr_i) + k == i) || (int'(ptr_i) + k == i + NREQ))) begin
               found = 1'b1;
               idx_o = SW'(i);
            end
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         grant_o[i] = en_i & found & (idx_o == SW'(i));
      end
   end

endmodule

// File: rtl/lieat_exu_share_rr.sv
// Shared ALU/branch/CSR execution unit: round-robin over NREQ requesters, registered result with
// valid/ready backpressure; shifts optionally run bit-serially (shamt+1 cycles).
module lieat_exu_share_rr #(
   parameter int XLEN         = 32,
   parameter int NREQ         = 3,
   parameter int SERIAL_SHIFT = 0,
   parameter int OPW          = 5
) (
   input logic                 clock,
   input logic                 reset,
   lieat_exu_share_rr_if.slave bus
);
   import lieat_exu_pkg::*;

   localparam int SW  = clog2(NREQ);
   localparam int SHW = clog2(XLEN);

   exu_state_e      state_q;
   logic [SW-1:0]   ptr_q, ptr_d, rsp_src_q, gidx;
   logic            rsp_valid_q, rsp_cmp_q;
   logic [XLEN-1:0] rsp_result_q, acc_q, acc_d;
   logic [SHW-1:0]  cnt_q;
   shctl_t          shctl_q, shctl_d;

   logic            accept_en, hs, is_shift, go_serial, ex_cmp;
   logic [NREQ-1:0] grant;
   op_t             op_g;
   logic [XLEN-1:0] op1_g, op2_g, ex_res;
   logic [SHW-1:0]  shamt;

   // Compares share one XLEN+1-bit subtract per signedness so the borrow is exact.
   function automatic logic [XLEN:0] exec(input op_t op, input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
      logic [XLEN:0]   du, ds;
      logic [SHW-1:0]  sh;
      logic [XLEN-1:0] r;
      logic            c;
      du = {1'b0, a} - {1'b0, b};
      ds = {a[XLEN-1], a} - {b[XLEN-1], b};
      sh = b[SHW-1:0];
      r  = '0;
      c  = 1'b0;
      case (op)
         OP_ADD:  r = a + b;
         OP_SUB:  r = du[XLEN-1:0];
         OP_XOR:  r = a ^ b;
         OP_OR:   r = a | b;
         OP_AND:  r = a & b;
         OP_SLL:  r = a << sh;
         OP_SRL:  r = a >> sh;
         OP_SRA:  r = $signed(a) >>> sh;
         OP_SLT:  r = XLEN'(ds[XLEN]);
         OP_SLTU: r = XLEN'(du[XLEN]);
         OP_LUI:  r = b;
         OP_BEQ:  c = ~|ds[XLEN-1:0];
         OP_BNE:  c = |ds[XLEN-1:0];
         OP_BLT:  c = ds[XLEN];
         OP_BGE:  c = ~ds[XLEN];
         OP_BLTU: c = du[XLEN];
         OP_BGEU: c = ~du[XLEN];
         default: ;
      endcase
      return {c, r};
   endfunction

   assign accept_en = ~reset & ((state_q == IDLE) | ((state_q == OUT) & bus.rsp_ready));

   lieat_rr_arb #(.NREQ(NREQ), .SW(SW)) u_arb (
      .req_i   (bus.req_valid),
      .ptr_i   (ptr_q),
      .en_i    (accept_en),
      .grant_o (grant),
      .idx_o   (gidx)
   );

   assign bus.req_ready = grant;
   assign hs            = |grant;

   always_comb begin
      op_g  = '0;
      op1_g = '0;
      op2_g = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gidx == SW'(i)) begin
            op_g  = op_t'(bus.req_op[i*OPW +: OPW]);
            op1_g = bus.req_op1[i*XLEN +: XLEN];
            op2_g = bus.req_op2[i*XLEN +: XLEN];
         end
      end
   end

   assign {ex_cmp, ex_res} = exec(op_g, op1_g, op2_g);

   assign shamt     = op2_g[SHW-1:0];
   assign is_shift  = (op_g == OP_SLL) | (op_g == OP_SRL) | (op_g == OP_SRA);
   assign go_serial = (SERIAL_SHIFT != 0) & is_shift & (shamt != '0);
   assign shctl_d   = '{left: (op_g == OP_SLL), arith: (op_g == OP_SRA)};
   assign ptr_d     = (gidx == SW'(NREQ-1)) ? '0 : gidx + SW'(1);

   assign acc_d = shctl_q.left ? {acc_q[XLEN-2:0], 1'b0}
                               : {shctl_q.arith & acc_q[XLEN-1], acc_q[XLEN-1:1]};

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_cmp_q    <= 1'b0;
         rsp_src_q    <= '0;
         acc_q        <= '0;
         cnt_q        <= '0;
         shctl_q      <= '0;
      end else begin
         case (state_q)
            SHIFT: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q - SHW'(1);
               if (cnt_q == SHW'(1)) begin
                  rsp_result_q <= acc_d;
                  rsp_cmp_q    <= 1'b0;
                  rsp_valid_q  <= 1'b1;
                  state_q      <= OUT;
               end
            end
            default: begin
               if ((state_q == OUT) && bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
               // A handshake in OUT implies rsp_ready, so the previous result has been taken.
               if (hs) begin
                  ptr_q     <= ptr_d;
                  rsp_src_q <= gidx;
                  if (go_serial) begin
                     acc_q   <= op1_g;
                     cnt_q   <= shamt;
                     shctl_q <= shctl_d;
                     state_q <= SHIFT;
                  end else begin
                     rsp_result_q <= ex_res;
                     rsp_cmp_q    <= ex_cmp;
                     rsp_valid_q  <= 1'b1;
                     state_q      <= OUT;
                  end
               end
            end
         endcase
      end
   end

   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_cmp    = rsp_cmp_q;
   assign bus.rsp_src    = rsp_src_q;

endmodule

// File: tb/tb_lieat_exu_share_rr.sv
// Bench for lieat_exu_share_rr (XLEN=32, NREQ=3, serial shifts): cycle model plus directed literals.
module tb_lieat_exu_share_rr;
   import lieat_exu_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   lieat_exu_share_rr_if #(.XLEN(32), .NREQ(3), .OPW(5)) bus ();

   lieat_exu_share_rr #(.XLEN(32), .NREQ(3), .SERIAL_SHIFT(1), .OPW(5)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic void golden(input op_t op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic c);
      int unsigned sh;
      sh = b[4:0];
      r  = 32'd0;
      c  = 1'b0;
      case (op)
         OP_ADD:  r = a + b;
         OP_SUB:  r = a - b;
         OP_XOR:  r = a ^ b;
         OP_OR:   r = a | b;
         OP_AND:  r = a & b;
         OP_SLL:  r = a << sh;
         OP_SRL:  r = a >> sh;
         OP_SRA:  r = $signed(a) >>> sh;
         OP_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         OP_SLTU: r = (a < b) ? 32'd1 : 32'd0;
         OP_LUI:  r = b;
         OP_BEQ:  c = (a == b);
         OP_BNE:  c = (a != b);
         OP_BLT:  c = ($signed(a) < $signed(b));
         OP_BGE:  c = ($signed(a) >= $signed(b));
         OP_BLTU: c = (a < b);
         OP_BGEU: c = (a >= b);
         default: ;
      endcase
   endfunction

   // Cycle model: pointer, pending shift countdown, and the held response.
   int          m_ptr = 0, m_busy = 0, m_src = 0, p_src = 0;
   bit          m_vld = 0, m_cmp = 0;
   logic [31:0] m_res = 0, p_res = 0;

   always @(negedge clk) begin
      bit          accept;
      int          g;
      logic [2:0]  exp_rdy;
      op_t         op;
      logic [31:0] a, b, r;
      logic        c;
      accept = !rst && (m_busy == 0) && (!m_vld || bus.rsp_ready);
      g = -1;
      for (int k = 0; k < 3; k++)
         if (g < 0 && bus.req_valid[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
      exp_rdy = (accept && g >= 0) ? 3'(1 << g) : 3'b000;
      chk("m_req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      chk("m_rsp_valid", 64'(bus.rsp_valid), 64'(m_vld));
      if (m_vld) begin
         chk("m_rsp_result", 64'(bus.rsp_result), 64'(m_res));
         chk("m_rsp_cmp", 64'(bus.rsp_cmp), 64'(m_cmp));
         chk("m_rsp_src", 64'(bus.rsp_src), 64'(m_src));
      end
      if (rst) begin
         m_ptr = 0; m_busy = 0; m_vld = 0; m_res = 0; m_cmp = 0; m_src = 0;
      end else begin
         if (m_vld && bus.rsp_ready) m_vld = 0;
         if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
               m_vld = 1; m_res = p_res; m_cmp = 0; m_src = p_src;
            end
         end else if (exp_rdy != 3'b000) begin
            op = op_t'(bus.req_op[g*5 +: 5]);
            a  = bus.req_op1[g*32 +: 32];
            b  = bus.req_op2[g*32 +: 32];
            golden(op, a, b, r, c);
            m_ptr = (g + 1) % 3;
            if ((op == OP_SLL || op == OP_SRL || op == OP_SRA) && b[4:0] != 5'd0) begin
               m_busy = int'(b[4:0]); p_res = r; p_src = g;
            end else begin
               m_vld = 1; m_res = r; m_cmp = c; m_src = g;
            end
         end
      end
   end

   task automatic setreq(input int ch, input op_t op, input logic [31:0] a, input logic [31:0] b);
      bus.req_op[ch*5 +: 5]   = op;
      bus.req_op1[ch*32 +: 32] = a;
      bus.req_op2[ch*32 +: 32] = b;
   endtask

   task automatic do_req(input string nm, input int ch, input op_t op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input logic ec, input int elat);
      int n;
      bit got;
      @(posedge clk); #1;
      setreq(ch, op, a, b);
      bus.req_valid[ch] = 1'b1;
      n = 0; got = 0;
      while (!got && n < 50) begin
         @(negedge clk);
         got = bus.req_ready[ch];
         @(posedge clk); #1;
         n++;
      end
      bus.req_valid[ch] = 1'b0;
      chk({nm, "_accepted"}, 64'(got), 64'd1);
      n = 1; got = 0;
      while (!got && n < 100) begin
         @(negedge clk);
         if (bus.rsp_valid) got = 1;
         else begin
            @(posedge clk); #1;
            n++;
         end
      end
      chk({nm, "_latency"}, 64'(n), 64'(elat));
      chk({nm, "_result"}, 64'(bus.rsp_result), 64'(er));
      chk({nm, "_cmp"}, 64'(bus.rsp_cmp), 64'(ec));
      chk({nm, "_src"}, 64'(bus.rsp_src), 64'(ch));
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int          exp_g[6];
      int          gnt, nv;
      logic [31:0] rv;
      exp_g = '{0, 1, 2, 0, 1, 2};
      bus.req_valid = '0;
      bus.req_op    = '0;
      bus.req_op1   = '0;
      bus.req_op2   = '0;
      bus.rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_result", 64'(bus.rsp_result), 64'd0);
      chk("rst_cmp", 64'(bus.rsp_cmp), 64'd0);
      chk("rst_src", 64'(bus.rsp_src), 64'd0);
      chk("rst_ready", 64'(bus.req_ready), 64'd0);

      do_req("add_wrap", 0, OP_ADD,  32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0, 1);
      do_req("slt",      0, OP_SLT,  32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1);
      do_req("sltu",     0, OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1);
      do_req("bge",      0, OP_BGE,  32'hFFFF_FFFB, 32'd3, 32'd0, 1'b0, 1);
      do_req("bgeu",     0, OP_BGEU, 32'hFFFF_FFFB, 32'd3, 32'd0, 1'b1, 1);
      do_req("beq",      0, OP_BEQ,  32'd7, 32'd7, 32'd0, 1'b1, 1);
      do_req("bne",      0, OP_BNE,  32'd7, 32'd7, 32'd0, 1'b0, 1);
      do_req("blt",      2, OP_BLT,  32'hFFFF_FFFB, 32'd3, 32'd0, 1'b1, 1);
      do_req("bltu",     2, OP_BLTU, 32'hFFFF_FFFB, 32'd3, 32'd0, 1'b0, 1);
      do_req("sub",      1, OP_SUB,  32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1);
      do_req("lui",      1, OP_LUI,  32'hDEAD_BEEF, 32'h1234_5000, 32'h1234_5000, 1'b0, 1);
      do_req("xor",      2, OP_XOR,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0, 1);
      do_req("undef",    0, op_t'(5'd31), 32'd9, 32'd9, 32'd0, 1'b0, 1);
      do_req("sll0",     0, OP_SLL,  32'd1, 32'd0, 32'd1, 1'b0, 1);
      do_req("sll_hi",   1, OP_SLL,  32'd1, 32'h21, 32'd2, 1'b0, 2);
      do_req("srl4",     2, OP_SRL,  32'hF0, 32'd4, 32'h0F, 1'b0, 5);
      do_req("sra1",     0, OP_SRA,  32'h4000_0000, 32'd1, 32'h2000_0000, 1'b0, 2);
      do_req("sra31",    0, OP_SRA,  32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 32);

      // all three channels valid back to back
      pulse_reset();
      for (int i = 0; i < 3; i++) setreq(i, OP_ADD, 32'(i * 16), 32'd1);
      bus.req_valid = 3'b111;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         gnt = -1;
         for (int i = 0; i < 3; i++) if (bus.req_ready[i]) gnt = i;
         chk("rr_grant", 64'(gnt), 64'(exp_g[c]));
         if (c > 0) chk("rr_valid", 64'(bus.rsp_valid), 64'd1);
         @(posedge clk); #1;
      end
      bus.req_valid = 3'b000;
      repeat (2) @(posedge clk);

      // consumer stalls while other requesters wait
      pulse_reset();
      bus.rsp_ready = 1'b0;
      setreq(0, OP_ADD, 32'd10, 32'd20);
      setreq(1, OP_ADD, 32'd5, 32'd6);
      setreq(2, OP_ADD, 32'd7, 32'd8);
      bus.req_valid = 3'b001;
      @(negedge clk);
      chk("bp_first_grant", 64'(bus.req_ready), 64'b001);
      @(posedge clk); #1;
      bus.req_valid = 3'b111;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("bp_hold_valid", 64'(bus.rsp_valid), 64'd1);
         chk("bp_hold_result", 64'(bus.rsp_result), 64'd30);
         chk("bp_hold_ready", 64'(bus.req_ready), 64'd0);
         @(posedge clk); #1;
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_grant", 64'(bus.req_ready), 64'b010);
      @(posedge clk); #1;
      bus.req_valid = 3'b000;
      @(negedge clk);
      chk("bp_next_src", 64'(bus.rsp_src), 64'd1);
      chk("bp_next_result", 64'(bus.rsp_result), 64'd11);
      repeat (2) @(posedge clk);

      // reset while a serial shift is in flight
      #1;
      setreq(1, OP_SRL, 32'hF000_0000, 32'd20);
      bus.req_valid = 3'b010;
      @(negedge clk);
      chk("rs_grant", 64'(bus.req_ready), 64'b010);
      @(posedge clk); #1;
      bus.req_valid = 3'b000;
      repeat (4) @(posedge clk);
      #1;
      setreq(0, OP_ADD, 32'd1, 32'd2);
      rst = 1'b1;
      bus.req_valid = 3'b111;
      @(negedge clk);
      chk("rs_ready_in_reset", 64'(bus.req_ready), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rs_valid_after", 64'(bus.rsp_valid), 64'd0);
      chk("rs_ptr_zero_grant", 64'(bus.req_ready), 64'b001);
      @(posedge clk); #1;
      bus.req_valid = 3'b000;
      nv = 0; rv = 32'd0;
      repeat (40) begin
         @(negedge clk);
         if (bus.rsp_valid) begin
            nv++;
            rv = bus.rsp_result;
         end
      end
      chk("rs_result_count", 64'(nv), 64'd1);
      chk("rs_only_new_result", 64'(rv), 64'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lieat_exu_share_rr.md
Name: lieat_exu_share_rr

Overview:
Parametrised shared execution unit that serves NREQ requesters (ALU, BJP, CSR, ...) through one datapath. Requesters use a valid/ready handshake and are served by a round-robin arbiter. The result is registered, with valid/ready backpressure toward the consumer. Shifts run either in a single cycle or, optionally, as a bit-serial multi-cycle operation to save area.

Parameters:
XLEN, 32, datapath width; must be 32 or 64.
NREQ, 3, number of requester channels; must be at least 2.
SERIAL_SHIFT, 0, 0 = single-cycle barrel shift; 1 = iterative shift, 1 bit per cycle.
OPW, 5, opcode width; encodings live in lieat_exu_pkg.

Ports:
clock  in  1  core clock.
reset  in  1  synchronous, active-high reset.
req_valid  in  NREQ  per-channel request valid.
req_ready  out  NREQ  per-channel accept; at most one bit set.
req_op  in  NREQ*OPW  channel i opcode at bits [i*OPW +: OPW].
req_op1  in  NREQ*XLEN  operand 1 per channel.
req_op2  in  NREQ*XLEN  operand 2 per channel (shamt in low log2(XLEN) bits).
rsp_valid  out  1  result held valid.
rsp_ready  in  1  consumer accepts the result.
rsp_result  out  XLEN  registered result.
rsp_cmp  out  1  branch-compare outcome; 0 for non-compare ops.
rsp_src  out  clog2(NREQ)  index of the channel that issued this result.

Behaviour:
- Opcodes: ADD SUB XOR OR AND SLL SRL SRA SLT SLTU LUI BEQ BNE BLT BGE BLTU BGEU.
  - ADD and SUB wrap modulo 2^XLEN.
  - SLT and SLTU return 1 or 0 in bit 0.
  - LUI returns op2.
  - Compare ops: rsp_result = 0; rsp_cmp carries the outcome. BLT/BGE are signed; BLTU/BGEU are unsigned. Compares use an XLEN+1-bit subtract so the borrow is exact.
  - Undefined opcode: rsp_result = 0, rsp_cmp = 0. The request still completes and is never dropped.
- Shifts:
  - shamt = op2[clog2(XLEN)-1:0]; upper bits are ignored.
  - SRA fills with op1[XLEN-1].
- FSM states: IDLE, SHIFT, OUT.
  - accept_en = (state==IDLE) | (state==OUT & rsp_ready).
  - Arbiter: grant = first req_valid at or after ptr, searching with wrap. req_ready = grant & {NREQ{accept_en}}.
  - A handshake occurs on channel g when req_valid[g] & req_ready[g]. On a handshake, ptr <= (g+1) mod NREQ. ptr does not change otherwise.
  - req_ready is combinational from req_valid, ptr and state. Requesters must not make req_valid depend on req_ready.
- Handshake, non-serial path (any op except a SLL/SRL/SRA with SERIAL_SHIFT=1 and shamt!=0):
  - Result, cmp and src are loaded into the output registers.
  - Next state OUT; rsp_valid = 1 the next cycle.
  - Latency 1 cycle; throughput 1 per cycle while rsp_ready stays high.
- Handshake, serial path (shift op, SERIAL_SHIFT=1, shamt!=0):
  - Load acc = op1, cnt = shamt, dir/arith flags and src; next state SHIFT.
- SHIFT state:
  - Each cycle acc shifts 1 bit in the selected direction and cnt decrements.
  - When cnt==1, the final shift writes rsp_result and the state moves to OUT.
  - Latency is shamt+1 cycles; req_ready is 0 throughout.
- OUT state:
  - rsp_valid = 1; rsp_result, rsp_cmp and rsp_src stay stable until rsp_ready.
  - rsp_ready with no new handshake: rsp_valid drops next cycle and state goes to IDLE.
  - rsp_ready with a simultaneous handshake: the new result loads and rsp_valid stays 1, giving back-to-back results.
- Reset:
  - state = IDLE, ptr = 0, rsp_valid = 0, rsp_result = 0, rsp_cmp = 0, rsp_src = 0, acc = 0, cnt = 0.
  - Reset during SHIFT or OUT discards the operation in progress. req_ready = 0 during the reset cycle.
- Boundary cases:
  - shamt = 0 with serial shift: single-cycle path; result = op1.
  - shamt = XLEN-1: XLEN cycles of latency.
  - All channels valid: each is served in turn ptr, ptr+1, ..., with no starvation; worst-case wait is NREQ-1 grants.

Decomposition:
- lieat_exu_pkg: opcode localparams (OP_ADD .. OP_BGEU), OPW, and a clog2 function.
- Sub-module lieat_rr_arb (NREQ): inputs req, ptr, en; output one-hot grant and encoded index.
- The combinational op datapath stays inline as a function or always block.

Test Plan:
- Single channel 0: ADD 0xFFFFFFFF + 1 -> rsp_valid 1 cycle later, result 0x0, rsp_src 0. SLT(-1, 1) -> result 1. SLTU(-1, 1) -> result 0.
- BGE(-5, 3) -> rsp_cmp 0, result 0. BGEU(0xFFFFFFFB, 3) -> rsp_cmp 1. BEQ(7, 7) -> rsp_cmp 1. BNE(7, 7) -> rsp_cmp 0.
- All 3 channels valid continuously with rsp_ready = 1 -> grants 0,1,2,0,1,2 on consecutive cycles; rsp_valid held high; rsp_src sequence matches.
- rsp_ready held 0 for 4 cycles while in OUT -> rsp_result stable, req_ready all 0, ptr unchanged. Release -> next grant on the following channel.
- SERIAL_SHIFT=1, SRA(0x80000000, 31) -> req_ready low for 31 cycles; result 0xFFFFFFFF at cycle 32. SLL(0x1, 0) -> 1-cycle path, result 0x1.
- Assert reset during the SHIFT of SRL(0xF0000000, 20) at cycle 5 -> next cycle state IDLE, rsp_valid 0, ptr 0, no stale result appears afterwards.
